br_resolve: RTL

- Branch resolution stage directly downstream of the N/Z/P condition-code register.
- Compares a BR instruction's nzp mask (IR[11:9]) against the current N, Z, P flags and decides taken or not taken.
- Stalls while an older in-flight instruction still has a pending condition-code write.
- On a taken branch: issues a one-cycle PC redirect, then squashes younger pipeline stages for a fixed number of cycles.

---
 rtl/br_resolve.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/br_resolve.sv
// Branch resolution stage: evaluates BR nzp mask against the condition codes,
// stalls on pending CC writes, redirects fetch and flushes younger stages.
// Optional BR_STATS_EN adds saturating total/taken branch counters.
module br_resolve #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              br_valid,
    input  logic [2:0]        br_nzp,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              N,
    input  logic              Z,
    input  logic              P,
    input  logic              cc_pending,
    output logic              br_ready,
    output logic              stall,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush
`ifdef BR_STATS_EN
    ,
    output logic [15:0]       br_total_cnt,
    output logic [15:0]       br_taken_cnt
`endif
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_CC = 2'd1,
        FLUSH   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          mask_q, mask_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic                redirect_q, redirect_d;
    logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic                flush_q, flush_d;

    logic                ready_c;
    logic                stall_c;
    logic                taken_c;
    logic [2:0]          sel_mask_c;
    logic [ADDR_W-1:0]   sel_target_c;

    // State and registered outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mask_q        <= '0;
            target_q      <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            target_q      <= target_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            flush_q       <= flush_d;
        end
    end

    // Next-state, resolution and handshake
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mask_d        = mask_q;
        target_d      = target_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        flush_d       = 1'b0;
        ready_c       = 1'b0;
        stall_c       = 1'b0;
        sel_mask_c    = br_nzp;
        sel_target_c  = br_target;

        unique case (state_q)
            IDLE: begin
                if (br_valid) begin
                    if (cc_pending) begin
                        stall_c  = 1'b1;
                        mask_d   = br_nzp;
                        target_d = br_target;
                        state_d  = WAIT_CC;
                    end else begin
                        ready_c = 1'b1;
                    end
                end
            end
            WAIT_CC: begin
                sel_mask_c   = mask_q;
                sel_target_c = target_q;
                if (cc_pending) begin
                    stall_c = 1'b1;
                end else begin
                    ready_c = 1'b1;
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    flush_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        taken_c = ready_c && ((sel_mask_c & {N, Z, P}) != 3'b000);

        if (taken_c) begin
            redirect_d    = 1'b1;
            redirect_pc_d = sel_target_c;
            flush_d       = 1'b1;
            cnt_d         = CNT_W'(FLUSH_CYCLES - 1);
            state_d       = FLUSH;
        end
    end

    // Handshake outputs are forced low while reset is held
    assign br_ready    = ready_c & Reset_n;
    assign stall       = stall_c & Reset_n;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign flush       = flush_q;

`ifdef BR_STATS_EN
    logic [STAT_W-1:0] total_q, total_d;
    logic [STAT_W-1:0] taken_cnt_q, taken_cnt_d;

    // Saturating branch statistics
    always_comb begin
        total_d     = total_q;
        taken_cnt_d = taken_cnt_q;
        if (ready_c && (total_q != {STAT_W{1'b1}})) begin
            total_d = total_q + STAT_W'(1);
        end
        if (taken_c && (taken_cnt_q != {STAT_W{1'b1}})) begin
            taken_cnt_d = taken_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            total_q     <= '0;
            taken_cnt_q <= '0;
        end else begin
            total_q     <= total_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign br_total_cnt = total_q;
    assign br_taken_cnt = taken_cnt_q;
`endif

endmodule
